// File: rtl/layer_mem_resp.sv
// Two-bank layer memory (4096x13 / 1024x13) with a host read/write port and a bank dump streamer.
// Define LMEM_RANGE_CHECK_EN to reject out-of-range layer1 accesses and raise a sticky err flag.
module layer_mem_resp (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csel,
    input  logic        cwr,
    input  logic [11:0] caddr_wr,
    input  logic [12:0] cdata_wr,
    input  logic        crd,
    input  logic [11:0] caddr_rd,
    output logic [12:0] cdata_rd,
    input  logic        dump_start,
    input  logic        dump_sel,
    output logic        dump_busy,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [11:0] dump_addr,
    output logic [12:0] dump_data,
    output logic        dump_last,
    output logic        err
);
    localparam int unsigned AW  = 12;
    localparam int unsigned AW1 = 10;
    localparam int unsigned DW  = 13;
    localparam int unsigned D0  = 4096;
    localparam int unsigned D1  = 1024;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    logic [DW-1:0] mem0 [D0];
    logic [DW-1:0] mem1 [D1];

    logic wr_ok;
    logic rd_ok;

`ifdef LMEM_RANGE_CHECK_EN
    logic wr_oob;
    logic rd_oob;
    logic err_q;

    assign wr_oob = csel && (caddr_wr[AW-1:AW1] != 2'b00);
    assign rd_oob = csel && (caddr_rd[AW-1:AW1] != 2'b00);
    assign wr_ok  = !wr_oob;
    assign rd_ok  = !rd_oob;

    // Sticky until reset: any rejected access latches the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if ((cwr && wr_oob) || (crd && rd_oob)) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
    assign err   = 1'b0;
`endif

    // Storage is intentionally not reset; layer1 aliases on the low address bits.
    always_ff @(posedge clk) begin
        if (cwr && wr_ok) begin
            if (csel) begin
                mem1[caddr_wr[AW1-1:0]] <= cdata_wr;
            end else begin
                mem0[caddr_wr] <= cdata_wr;
            end
        end
    end

    always_comb begin
        cdata_rd = '0;
        if (crd && rd_ok) begin
            cdata_rd = csel ? mem1[caddr_rd[AW1-1:0]] : mem0[caddr_rd];
        end
    end

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          valid_d, last_d, busy_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;
    logic [DW-1:0] load_word;
    logic [AW-1:0] last_ptr;

    assign load_word = sel_q ? mem1[ptr_q[AW1-1:0]] : mem0[ptr_q];
    assign last_ptr  = sel_q ? AW'(D1 - 1) : AW'(D0 - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            ptr_q      <= '0;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_last  <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            dump_valid <= valid_d;
            dump_busy  <= busy_d;
            dump_last  <= last_d;
            dump_addr  <= addr_d;
            dump_data  <= data_d;
        end
    end

    // Dump sequencing: LOAD snapshots one word, SEND holds it until accepted.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        valid_d = dump_valid;
        last_d  = dump_last;
        addr_d  = dump_addr;
        data_d  = dump_data;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    sel_d   = dump_sel;
                    ptr_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = load_word;
                addr_d  = ptr_q;
                last_d  = (ptr_q == last_ptr);
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    if (dump_last) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end
endmodule

// File: tb/tb_layer_mem_resp.sv
// Self-checking bench for layer_mem_resp: host port checks plus a scoreboard on the dump stream.
// Expectations follow LMEM_RANGE_CHECK_EN when it is defined for the build.
module tb_layer_mem_resp;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        csel, cwr, crd;
    logic [11:0] caddr_wr, caddr_rd;
    logic [12:0] cdata_wr;
    logic [12:0] cdata_rd;
    logic        dump_start, dump_sel, dump_busy, dump_valid, dump_ready;
    logic [11:0] dump_addr;
    logic [12:0] dump_data;
    logic        dump_last;
    logic        err;

    typedef struct {
        logic [11:0] addr;
        logic [12:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [12:0] m0 [4096];
    logic [12:0] m1 [1024];
    int          total = 0;
    int          bad = 0;

    layer_mem_resp dut (
        .clk(clk), .reset_n(reset_n), .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .dump_start(dump_start), .dump_sel(dump_sel), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_last(dump_last), .err(err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted dump word must match the next queued expectation.
    always @(negedge clk) begin
        if (reset_n && dump_valid && dump_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dump_extra_word addr=%0d data=%h expected no word", dump_addr, dump_data);
            end else begin
                e = exp_q.pop_front();
                if ({dump_addr, dump_data, dump_last, dump_busy} !== {e.addr, e.data, e.last, 1'b1}) begin
                    bad++;
                    $display("FAIL dump_word got addr=%0d data=%h last=%b busy=%b expected addr=%0d data=%h last=%b busy=1",
                             dump_addr, dump_data, dump_last, dump_busy, e.addr, e.data, e.last);
                end
            end
        end
    end

    task automatic host_write(input logic s, input logic [11:0] a, input logic [12:0] d);
        csel = s; cwr = 1'b1; caddr_wr = a; cdata_wr = d;
        if (s) begin
`ifdef LMEM_RANGE_CHECK_EN
            if (a[11:10] == 2'b00) m1[a[9:0]] = d;
`else
            m1[a[9:0]] = d;
`endif
        end else begin
            m0[a] = d;
        end
        @(posedge clk); #1;
        cwr = 1'b0;
    endtask

    task automatic start_dump(input logic s);
        int depth;
        depth = s ? 1024 : 4096;
        for (int i = 0; i < depth; i++) begin
            exp_q.push_back('{addr: 12'(i), data: (s ? m1[i] : m0[i]), last: (i == depth - 1)});
        end
        dump_start = 1'b1; dump_sel = s;
        @(posedge clk); #1;
        dump_start = 1'b0;
    endtask

    task automatic wait_dump_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL dump_timeout remaining=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        total++;
        if (dump_busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_last got=%b expected 0", dump_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 7;
        if (dump_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b expected 0", dump_valid); end
        if (dump_busy !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b expected 0", dump_busy); end
        if (dump_last !== 1'b0)  begin bad++; $display("FAIL rst_last got=%b expected 0", dump_last); end
        if (dump_addr !== 12'd0) begin bad++; $display("FAIL rst_addr got=%h expected 0", dump_addr); end
        if (dump_data !== 13'd0) begin bad++; $display("FAIL rst_data got=%h expected 0", dump_data); end
        if (err !== 1'b0)        begin bad++; $display("FAIL rst_err got=%b expected 0", err); end
        if (cdata_rd !== 13'd0)  begin bad++; $display("FAIL rst_rd got=%h expected 0", cdata_rd); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_write();
        host_write(1'b0, 12'd5, 13'h0ABC);
        crd = 1'b1; csel = 1'b0; caddr_rd = 12'd5;
        @(negedge clk);
        total++;
        if (cdata_rd !== 13'h0ABC) begin bad++; $display("FAIL rd_addr5 got=%h expected 0abc", cdata_rd); end
        @(posedge clk); #1;
        crd = 1'b0;
        @(negedge clk);
        total++;
        if (cdata_rd !== 13'd0) begin bad++; $display("FAIL rd_idle_zero got=%h expected 0", cdata_rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_same_cycle();
        host_write(1'b0, 12'd7, 13'h0022);
        crd = 1'b1; caddr_rd = 12'd7;
        csel = 1'b0; cwr = 1'b1; caddr_wr = 12'd7; cdata_wr = 13'h0011;
        m0[7] = 13'h0011;
        @(negedge clk);
        total++;
        if (cdata_rd !== 13'h0022) begin bad++; $display("FAIL rw_same_old got=%h expected 0022", cdata_rd); end
        @(posedge clk); #1;
        cwr = 1'b0;
        @(negedge clk);
        total++;
        if (cdata_rd !== 13'h0011) begin bad++; $display("FAIL rw_same_new got=%h expected 0011", cdata_rd); end
        @(posedge clk); #1;
        crd = 1'b0;
    endtask

    task automatic test_dump_layer1();
        for (int i = 0; i < 1024; i++) host_write(1'b1, 12'(i), 13'(i));
        dump_ready = 1'b1;
        start_dump(1'b1);
        repeat (40) @(posedge clk);
        #1;
        // A second start while busy must not restart or add words.
        dump_start = 1'b1; dump_sel = 1'b0;
        @(posedge clk); #1;
        dump_start = 1'b0;
        wait_dump_done();
    endtask

    task automatic test_stall();
        int n;
        n = 0;
        dump_ready = 1'b1;
        start_dump(1'b1);
        while (!(dump_valid && dump_addr == 12'd2) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        dump_ready = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if ({dump_valid, dump_addr, dump_data} !== {1'b1, 12'd3, m1[3]}) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got v=%b a=%0d d=%h expected v=1 a=3 d=%h",
                         k, dump_valid, dump_addr, dump_data, m1[3]);
            end
            @(posedge clk); #1;
        end
        dump_ready = 1'b1;
        wait_dump_done();
    endtask

    task automatic test_range();
        logic [12:0] exp6;
        logic        exp_err;
        host_write(1'b1, 12'd1030, 13'h1ABC);
`ifdef LMEM_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        exp6 = m1[6];
        crd = 1'b1; csel = 1'b1; caddr_rd = 12'd6;
        @(negedge clk);
        total += 2;
        if (err !== exp_err) begin bad++; $display("FAIL range_err got=%b expected %b", err, exp_err); end
        if (cdata_rd !== exp6) begin bad++; $display("FAIL range_addr6 got=%h expected %h", cdata_rd, exp6); end
        @(posedge clk); #1;
        crd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (err !== exp_err) begin bad++; $display("FAIL range_err_sticky got=%b expected %b", err, exp_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_dump();
        int n;
        int addrs[4] = '{0, 100, 101, 4095};
        for (int i = 0; i < 4096; i++) host_write(1'b0, 12'(i), 13'((i * 7 + 3) & 13'h1FFF));
        dump_ready = 1'b1;
        start_dump(1'b0);
        n = 0;
        while (!(dump_valid && dump_addr == 12'd100) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 1000) begin bad++; $display("FAIL reach_word100 got addr=%0d expected 100", dump_addr); end
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({dump_valid, dump_busy} !== 2'b00) begin
            bad++;
            $display("FAIL rst_abort got valid=%b busy=%b expected 0 0", dump_valid, dump_busy);
        end
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dump_valid !== 1'b0 || dump_busy !== 1'b0) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL post_reset_quiet got active_cycles=%0d expected 0", n); end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            crd = 1'b1; csel = 1'b0; caddr_rd = 12'(addrs[k]);
            @(negedge clk);
            total++;
            if (cdata_rd !== m0[addrs[k]]) begin
                bad++;
                $display("FAIL mem_keep addr=%0d got=%h expected %h", addrs[k], cdata_rd, m0[addrs[k]]);
            end
            @(posedge clk); #1;
        end
        crd = 1'b1; csel = 1'b1; caddr_rd = 12'd500;
        @(negedge clk);
        total++;
        if (cdata_rd !== m1[500]) begin bad++; $display("FAIL mem_keep_l1 got=%h expected %h", cdata_rd, m1[500]); end
        @(posedge clk); #1;
        crd = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        csel = 1'b0; cwr = 1'b0; crd = 1'b0;
        caddr_wr = '0; caddr_rd = '0; cdata_wr = '0;
        dump_start = 1'b0; dump_sel = 1'b0; dump_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_read_write();
        test_same_cycle();
        test_dump_layer1();
        test_stall();
        test_range();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_mem_resp.md
LAYER_MEM_RESP -- requirements
Module: layer_mem_resp

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: csel  input  1  bank select: 0 = layer0 (4096x13), 1 = layer1 (1024x13).
REQ-004 SHALL have port: cwr  input  1  write strobe.
REQ-005 SHALL have port: caddr_wr  input  12  write address.
REQ-006 SHALL have port: cdata_wr  input  13  write data.
REQ-007 SHALL have port: crd  input  1  read strobe.
REQ-008 SHALL have port: caddr_rd  input  12  read address.
REQ-009 SHALL have port: cdata_rd  output  13  read data, combinational.
REQ-010 SHALL have port: dump_start  input  1  one-cycle request to stream a whole bank out.
REQ-011 SHALL have port: dump_sel  input  1  bank to dump, sampled with dump_start.
REQ-012 SHALL have port: dump_busy  output  1  dump in progress.
REQ-013 SHALL have port: dump_valid / dump_ready  output / input  1 / 1  stream handshake.
REQ-014 SHALL have port: dump_addr / dump_data / dump_last  output  12 / 13 / 1  stream word, address, final-word flag.
REQ-015 SHALL have port: err  output  1  sticky range-error flag (see Configuration).

Function
REQ-016 Write SHALL occur at rising edge when cwr=1: bank[csel][caddr_wr] <= cdata_wr.
REQ-017 cdata_rd SHALL equal bank[csel][caddr_rd] combinationally while crd=1, and 13'd0 while crd=0.
REQ-018 Read and write to the same address in the same cycle SHALL return pre-edge (old) data on cdata_rd.
REQ-019 cwr and crd both high SHALL be legal; both operations occur independently.
REQ-020 Dump FSM states SHALL be IDLE, LOAD, SEND.
REQ-021 IDLE: dump_start=1 SHALL latch dump_sel, clear pointer to 0, go LOAD; otherwise stay.
REQ-022 LOAD: SHALL register dump_data=bank[sel][ptr], dump_addr=ptr, dump_last=(ptr==depth-1), set dump_valid=1, go SEND.
REQ-023 SEND: dump_valid=1 and dump_ready=1 SHALL complete the word; if dump_last, clear dump_valid and go IDLE; else ptr+1, clear dump_valid, go LOAD.
REQ-024 SEND with dump_ready=0 SHALL hold dump_valid, dump_data, dump_addr, dump_last unchanged.
REQ-025 Depth SHALL be 4096 for sel=0 and 1024 for sel=1; throughput one word per two cycles with dump_ready held high.
REQ-026 dump_busy SHALL be 1 in LOAD and SEND, 0 in IDLE.
REQ-027 dump_start while dump_busy=1 SHALL be ignored.
REQ-028 Host writes during a dump SHALL be allowed; a dumped word reflects bank contents at its LOAD cycle.

Reset
REQ-029 reset_n=0 SHALL immediately force FSM to IDLE, pointer 0, dump_valid/dump_busy/dump_last/err to 0, dump_data/dump_addr to 0.
REQ-030 Memory contents SHALL NOT be reset; reset mid-dump SHALL abort the dump with no further words.

Configuration
REQ-031 With LMEM_RANGE_CHECK_EN defined: any cwr or crd with csel=1 and address bits [11:10]!=0 SHALL suppress the write, drive cdata_rd=0, and set err (sticky until reset).
REQ-032 Without LMEM_RANGE_CHECK_EN: layer1 SHALL use address bits [9:0] only (aliasing), err SHALL be tied 0.

Verification
REQ-033 Write csel=0 addr 12'd5 data 13'h0ABC, then crd addr 5 -> cdata_rd=13'h0ABC same cycle; crd=0 -> 13'd0.
REQ-034 Same cycle cwr addr 7 data 13'h0011 (old 13'h0022) and crd addr 7 -> cdata_rd=13'h0022 that cycle, 13'h0011 next cycle.
REQ-035 Fill layer1 with data=addr, dump_start sel=1, dump_ready=1 -> 1024 words, addresses 0..1023 in order, dump_last only on addr 1023, dump_busy falls after it.
REQ-036 dump_ready held 0 for 5 cycles on word 3 -> dump_data/dump_addr stable, no word skipped or duplicated.
REQ-037 reset_n pulsed low during layer0 dump at word 100 -> dump_valid, dump_busy 0 immediately; memory contents preserved on readback.
REQ-038 With LMEM_RANGE_CHECK_EN: cwr csel=1 addr 12'd1030 -> bank unchanged at 12'd6, err=1 and stays 1; without macro -> addr 6 written, err=0.
